nv_blkbox_sink_misr: RTL
========================

Name: nv_blkbox_sink_misr

Overview:
Parametrised, observable successor to the single-bit black-box sink. Terminates an arbitrary-width bundle of otherwise-unused nets so synthesis cannot prune their fan-in cones. Compresses the nets into a multiple-input signature register (MISR) and counts data toggles, so DFT and debug can confirm the cones are live. Instantiated at partition boundaries and on spare or tie-off buses in the core clock domain.

Parameters:
- WIDTH, 32, width of sink_data (1..256).
- SIG_W, 32, signature register width (8..64).
- POLY, 32'h04C11DB7, MISR feedback polynomial; low SIG_W bits used.
- SEED, 32'h0, signature value after reset or clear; low SIG_W bits used.
- CNT_W, 16, toggle counter width (2..32).

Ports:
- nvdla_core_clk, input, 1, core clock.
- nvdla_core_rstn, input, 1, asynchronous active-low reset.
- sink_data, input, WIDTH, nets being sunk.
- sink_vld, input, 1, sink_data qualifier; beat accepted when state==RUN and sink_vld==1.
- sink_en, input, 1, level enable for compression.
- freeze, input, 1, pulse; holds signature and count for readout.
- clr, input, 1, synchronous clear pulse.
- sig_out, output, SIG_W, current signature.
- toggle_cnt, output, CNT_W, number of accepted beats whose data differed from the previous accepted beat.
- cnt_sat, output, 1, sticky; toggle_cnt has reached all-ones.
- frozen, output, 1, state==FROZEN.

Behaviour:
- Reset (async assert, synchronous deassert handled externally): state=IDLE, sig_out=SEED, toggle_cnt=0, cnt_sat=0, frozen=0, prev_data=0.
- States and transitions:
  - IDLE -> RUN when sink_en=1.
  - RUN -> IDLE when sink_en=0.
  - RUN -> FROZEN on freeze=1.
  - FROZEN -> RUN or IDLE (chosen by current sink_en) only on clr=1.
  - freeze in IDLE is ignored.
- Fold:
  - Split sink_data into ceil(WIDTH/SIG_W) SIG_W-bit slices, LSB slice first; zero-pad the top slice; XOR all slices together to give fold.
  - If WIDTH<SIG_W, fold is sink_data zero-extended.
- MISR update on an accepted beat: sig_next = (sig<<1) ^ (sig[SIG_W-1] ? POLY : 0) ^ fold.
- sig_out is registered; it reflects the beat one cycle after acceptance. There is no update when no beat is accepted.
- Toggle counting on an accepted beat:
  - If sink_data != prev_data, toggle_cnt increments by 1, saturating at all-ones.
  - prev_data <= sink_data on every accepted beat.
  - cnt_sat sets in the same cycle toggle_cnt becomes all-ones and stays set until clr or reset.
- clr has top priority:
  - Resets sig_out=SEED, toggle_cnt=0, cnt_sat=0, prev_data=0.
  - State goes to RUN if sink_en=1, else IDLE.
  - A beat presented in the same cycle is dropped.
  - Simultaneous freeze is ignored.
- freeze together with an accepted beat in RUN: the beat is compressed, then the block enters FROZEN. Post-freeze values include that beat.
- In FROZEN, sink_vld and sink_en are ignored and all outputs are held.
- Reset asserted mid-operation: all state returns to reset values immediately. No partial update survives.
- No X propagation: X on sink_data while sink_vld=0 must not disturb any register.

Test Plan:
- Basic MISR (WIDTH=32, SIG_W=32, SEED=0): sink_en=1; beat 0x00000001, then beat 0x00000000 -> sig_out = 0x00000001 one cycle after the first beat, 0x00000002 after the second; toggle_cnt = 1 then 2 (0 vs 0 is no toggle before the first beat; 1 then 0 toggles).
- Feedback (SEED=0xFFFFFFFF): single beat data 0 -> sig_out = 0xFB3EE249.
- Fold (WIDTH=40, SIG_W=32, SEED=0): beat 40'hAB_0000_0001 -> sig_out = 0x000000AA.
- Saturation (CNT_W=4): 16 beats alternating 0x5/0xA starting at 0x5 -> toggle_cnt stops at 15; cnt_sat=1 from the 15th beat; a further toggling beat leaves toggle_cnt=15.
- Freeze and clear: freeze coincident with beat 0x1 (SEED=0) -> frozen=1, sig_out=0x1, held over 10 further valid beats. Then clr with sink_en=1 and a coincident beat -> sig_out=0, toggle_cnt=0, frozen=0, coincident beat dropped, RUN resumes.
- Async reset mid-stream: assert nvdla_core_rstn low between clock edges after 3 beats -> all outputs at reset values before the next edge. Enable-off case: sink_en=0 with sink_vld=1 and X on sink_data -> no output change.

Source files
------------

// File: rtl/nv_blkbox_sink_misr.sv
// nv_blkbox_sink_misr
//
// Terminates a bundle of otherwise-unused nets so synthesis keeps their fan-in
// cones. The nets are folded into a multiple-input signature register (MISR).
// Data toggles between accepted beats are also counted, so DFT and debug can
// confirm that the cones are live.
//
// Ports
//   nvdla_core_clk   core clock
//   nvdla_core_rstn  asynchronous active-low reset
//   sink_data        nets being sunk (WIDTH bits)
//   sink_vld         beat qualifier; a beat is accepted only in RUN
//   sink_en          level enable for compression (IDLE <-> RUN)
//   freeze           pulse; enters FROZEN from RUN and holds all outputs
//   clr              synchronous clear pulse, highest priority
//   sig_out          current signature (SIG_W bits)
//   toggle_cnt       accepted beats whose data differed from the previous one
//   cnt_sat          sticky flag: toggle_cnt has reached all-ones
//   frozen           high while in FROZEN
module nv_blkbox_sink_misr #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SIG_W = 32,
    parameter logic [63:0] POLY  = 64'h0000_0000_04C1_1DB7,
    parameter logic [63:0] SEED  = 64'h0,
    parameter int unsigned CNT_W = 16
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rstn,
    input  logic [WIDTH-1:0] sink_data,
    input  logic             sink_vld,
    input  logic             sink_en,
    input  logic             freeze,
    input  logic             clr,
    output logic [SIG_W-1:0] sig_out,
    output logic [CNT_W-1:0] toggle_cnt,
    output logic             cnt_sat,
    output logic             frozen
);

    localparam int unsigned NSLICE = (WIDTH + SIG_W - 1) / SIG_W;
    localparam int unsigned PAD_W  = NSLICE * SIG_W;

    localparam logic [SIG_W-1:0] POLY_W  = POLY[SIG_W-1:0];
    localparam logic [SIG_W-1:0] SEED_W  = SEED[SIG_W-1:0];
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFrozen
    } state_e;

    state_e             state_q, state_d;
    logic [SIG_W-1:0]   sig_q, sig_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sat_q, sat_d;
    logic [WIDTH-1:0]   prev_q, prev_d;

    logic [PAD_W-1:0]   padded;
    logic [SIG_W-1:0]   fold;
    logic               accept;

    // ------------------------------------------------------------------
    // Fold: XOR of all SIG_W-bit slices of the zero-padded input.
    // ------------------------------------------------------------------
    always_comb begin
        padded              = '0;
        padded[WIDTH-1:0]   = sink_data;
    end

    for (genvar s = 0; s < NSLICE; s++) begin : g_fold
        logic [SIG_W-1:0] part;
        if (s == 0) begin : g_first
            assign part = padded[SIG_W-1:0];
        end else begin : g_rest
            assign part = g_fold[s-1].part ^ padded[s*SIG_W +: SIG_W];
        end
    end

    assign fold = g_fold[NSLICE-1].part;

    // ------------------------------------------------------------------
    // Next-state logic. clr overrides everything, including a coincident
    // beat and freeze. A beat accepted together with freeze is still
    // compressed before the block parks in FROZEN.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        prev_d  = prev_q;
        accept  = 1'b0;

        if (clr) begin
            state_d = sink_en ? StRun : StIdle;
            sig_d   = SEED_W;
            cnt_d   = '0;
            sat_d   = 1'b0;
            prev_d  = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (sink_en) begin
                        state_d = StRun;
                    end
                end
                StRun: begin
                    accept = sink_vld;
                    if (freeze) begin
                        state_d = StFrozen;
                    end else if (!sink_en) begin
                        state_d = StIdle;
                    end
                end
                StFrozen: begin
                    state_d = StFrozen;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase

            // Only touch data-dependent state on an accepted beat, so an
            // unknown sink_data while sink_vld is low never reaches a flop.
            if (accept) begin
                sig_d = {sig_q[SIG_W-2:0], 1'b0}
                      ^ (sig_q[SIG_W-1] ? POLY_W : '0)
                      ^ fold;
                if (sink_data != prev_q) begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                sat_d  = sat_q | (cnt_d == CNT_MAX);
                prev_d = sink_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_q <= StIdle;
            sig_q   <= SEED_W;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            prev_q  <= '0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            prev_q  <= prev_d;
        end
    end

    assign sig_out    = sig_q;
    assign toggle_cnt = cnt_q;
    assign cnt_sat    = sat_q;
    assign frozen     = (state_q == StFrozen);

endmodule
